// File: rtl/dm_responder_pkg.sv
// Shared definitions for the multi-cycle data-memory responder:
// FSM state codes, access-size encoding and alignment helpers.
package dm_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_e;

  // Byte select wins over half select; neither means a full word.
  function automatic size_e size_of(input logic hf, input logic bt);
    size_e s;
    if (bt) begin
      s = SZ_BYTE;
    end else if (hf) begin
      s = SZ_HALF;
    end else begin
      s = SZ_WORD;
    end
    return s;
  endfunction

  function automatic logic misaligned(input size_e size, input logic [1:0] off);
    logic m;
    case (size)
      SZ_WORD: m = (off != 2'b00);
      SZ_HALF: m = off[0];
      SZ_BYTE: m = 1'b0;
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Load/store handshake between the datapath (master) and the data-memory
// responder (slave).
interface dm_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        hf;
  logic        bt;
  logic        ready;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wd, hf, bt,
    input  ready, ack, rdata, err
  );

  modport slave (
    input  req, we, addr, wd, hf, bt,
    output ready, ack, rdata, err
  );
endinterface

// File: rtl/dm_responder_lane_merge.sv
// Little-endian lane steering: merges store data into an existing word and
// extracts sign-extended load data from a word.
module dm_lane_merge
  import dm_responder_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wd_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection by access size and byte offset
  always_comb begin
    merged_o = old_i;
    load_o   = 32'h0000_0000;
    byte_s   = old_i[{off_i, 3'b000} +: 8];
    half_s   = old_i[{off_i[1], 4'b0000} +: 16];
    case (size_i)
      SZ_BYTE: begin
        merged_o[{off_i, 3'b000} +: 8] = wd_i[7:0];
        load_o = {{24{byte_s[7]}}, byte_s};
      end
      SZ_HALF: begin
        merged_o[{off_i[1], 4'b0000} +: 16] = wd_i[15:0];
        load_o = {{16{half_s[15]}}, half_s};
      end
      SZ_WORD: begin
        merged_o = wd_i;
        load_o   = old_i;
      end
      default: begin
        merged_o = old_i;
        load_o   = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store per handshake, serves it after
// LATENCY cycles and returns data or a misalignment error with a one-cycle ack.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input logic           clk,
  input logic           clr,
  dm_responder_if.slave bus
);

  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [1:0]            off_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wd_q;
  size_e                 size_q;
  logic                  ready_q, ack_q, err_q;
  logic [31:0]           rdata_q;
  logic [31:0]           mem_q [DEPTH];

  logic                  accept_s;
  size_e                 in_size_s;
  logic                  cur_we_s;
  logic [1:0]            cur_off_s;
  logic [DEPTH_LOG2-1:0] cur_idx_s;
  logic [31:0]           cur_wd_s;
  size_e                 cur_size_s;
  logic                  mis_s;
  logic                  wr_s;
  logic [31:0]           merged_s;
  logic [31:0]           load_s;
  logic                  unused_addr_s;

  assign unused_addr_s = ^bus.addr[31:DEPTH_LOG2+2];
  assign in_size_s     = size_of(bus.hf, bus.bt);
  assign accept_s      = bus.req && ready_q && (state_q == ST_IDLE);

  // With LATENCY=1 the array write happens on the accept edge itself, so the
  // live bus fields must feed the datapath while still in IDLE.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_we_s   = bus.we;
      cur_off_s  = bus.addr[1:0];
      cur_idx_s  = bus.addr[DEPTH_LOG2+1:2];
      cur_wd_s   = bus.wd;
      cur_size_s = in_size_s;
    end else begin
      cur_we_s   = we_q;
      cur_off_s  = off_q;
      cur_idx_s  = idx_q;
      cur_wd_s   = wd_q;
      cur_size_s = size_q;
    end
  end

  assign mis_s = misaligned(cur_size_s, cur_off_s);
  assign wr_s  = (state_d == ST_RESP) && (state_q != ST_RESP) && cur_we_s && !mis_s;

  dm_lane_merge u_lane_merge (
    .size_i   (cur_size_s),
    .off_i    (cur_off_s),
    .old_i    (mem_q[cur_idx_s]),
    .wd_i     (cur_wd_s),
    .merged_o (merged_s),
    .load_o   (load_s)
  );

  // Next-state and latency counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          cnt_d   = LAT_M1;
          state_d = (LAT_M1 == 4'd0) ? ST_RESP : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state, counter and request latch
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wd_q    <= 32'h0000_0000;
      size_q  <= SZ_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_s) begin
        we_q   <= bus.we;
        off_q  <= bus.addr[1:0];
        idx_q  <= bus.addr[DEPTH_LOG2+1:2];
        wd_q   <= bus.wd;
        size_q <= in_size_s;
      end
    end
  end

  // Registered response outputs; ack lands the cycle after RESP
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      ready_q <= (state_d == ST_IDLE);
      if (state_q == ST_RESP) begin
        ack_q   <= 1'b1;
        err_q   <= mis_s;
        rdata_q <= (!mis_s && !cur_we_s) ? load_s : 32'h0000_0000;
      end else begin
        ack_q   <= 1'b0;
        err_q   <= 1'b0;
        rdata_q <= 32'h0000_0000;
      end
    end
  end

  // Memory array; cleared on reset, written on the edge entering RESP
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (wr_s) begin
      mem_q[cur_idx_s] <= merged_s;
    end
  end

  assign bus.ready = ready_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a LATENCY=2 instance for most scenarios and
// a LATENCY=1 instance for the minimum-latency case.
module tb_dm_responder;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  dm_responder_if bus_a ();
  dm_responder_if bus_b ();

  dm_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut_a (
    .clk (clk),
    .clr (clr),
    .bus (bus_a.slave)
  );

  dm_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut_b (
    .clk (clk),
    .clr (clr),
    .bus (bus_b.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic drive(input bit sel, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic hf, input logic bt);
    if (!sel) begin
      bus_a.req = req; bus_a.we = we; bus_a.addr = addr;
      bus_a.wd = wd; bus_a.hf = hf; bus_a.bt = bt;
    end else begin
      bus_b.req = req; bus_b.we = we; bus_b.addr = addr;
      bus_b.wd = wd; bus_b.hf = hf; bus_b.bt = bt;
    end
  endtask

  function automatic logic get_ack(input bit sel);
    return sel ? bus_b.ack : bus_a.ack;
  endfunction

  // One request; lat counts edges from the accept edge to the first ack sample
  task automatic xfer(input bit sel, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic hf, input logic bt,
                      output int lat, output logic [31:0] rdata, output logic err);
    drive(sel, 1'b1, we, addr, wd, hf, bt);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    lat   = 99;
    rdata = 32'hDEAD_BEEF;
    err   = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (get_ack(sel)) begin
        lat   = n;
        rdata = sel ? bus_b.rdata : bus_a.rdata;
        err   = sel ? bus_b.err : bus_a.err;
        break;
      end
    end
  endtask

  // Checks latency, data and error flag of one transfer on the LATENCY=2 DUT
  task automatic check_xfer(input string name, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic hf, input logic bt,
                            input logic [31:0] exp_rd, input logic exp_err);
    int lat; logic [31:0] rd; logic e;
    xfer(1'b0, we, addr, wd, hf, bt, lat, rd, e);
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("FAIL %s latency: got %0d expected 2", name, lat);
    end
    vectors++;
    if (rd !== exp_rd) begin
      miscompares++;
      $display("FAIL %s rdata: got %h expected %h", name, rd, exp_rd);
    end
    vectors++;
    if (e !== exp_err) begin
      miscompares++;
      $display("FAIL %s err: got %b expected %b", name, e, exp_err);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus_a.ready, bus_a.ack, bus_a.err, bus_a.rdata} !== {3'b100, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got rdy/ack/err=%b%b%b rdata=%h expected 100 00000000",
               bus_a.ready, bus_a.ack, bus_a.err, bus_a.rdata);
    end
    @(negedge clk) clr = 1'b1;
    // store in flight, reset asserted mid-WAIT
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hCAFE_F00D, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (bus_a.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_ready: got %b expected 0", bus_a.ready);
    end
    #2 clr = 1'b0;
    #1;
    vectors++;
    if ({bus_a.ready, bus_a.ack} !== 2'b10) begin
      miscompares++;
      $display("FAIL midwait_reset: got rdy/ack=%b%b expected 10", bus_a.ready, bus_a.ack);
    end
    @(negedge clk) clr = 1'b1;
    @(posedge clk); #1;
    check_xfer("reset_load10", 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_word();
    check_xfer("word_store20", 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0);
    check_xfer("word_load20", 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_byte_half();
    check_xfer("byte_store21", 1'b1, 32'h21, 32'h0000_0080, 1'b0, 1'b1, 32'h0, 1'b0);
    check_xfer("byte_load21", 1'b0, 32'h21, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b0);
    check_xfer("word_after_byte", 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h1234_8078, 1'b0);
    check_xfer("half_store22", 1'b1, 32'h22, 32'h0000_7FFF, 1'b1, 1'b0, 32'h0, 1'b0);
    check_xfer("half_load22", 1'b0, 32'h22, 32'h0, 1'b1, 1'b0, 32'h0000_7FFF, 1'b0);
    check_xfer("half_load20", 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'hFFFF_8078, 1'b0);
    check_xfer("byte_load23", 1'b0, 32'h23, 32'h0, 1'b0, 1'b1, 32'h0000_007F, 1'b0);
    // bt has priority over hf: byte store of 0x11 into lane 0
    check_xfer("bt_over_hf", 1'b1, 32'h20, 32'hAAAA_AA11, 1'b1, 1'b1, 32'h0, 1'b0);
    check_xfer("word_after_bt", 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h7FFF_8011, 1'b0);
  endtask

  task automatic test_misaligned();
    check_xfer("mis_word22", 1'b0, 32'h22, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_xfer("mis_half23", 1'b1, 32'h23, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0, 1'b1);
    check_xfer("mis_word_st21", 1'b1, 32'h21, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b1);
    check_xfer("word20_intact", 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h7FFF_8011, 1'b0);
  endtask

  task automatic test_wrap();
    check_xfer("wrap_store1000", 1'b1, 32'h1000, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0, 1'b0);
    check_xfer("wrap_load0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hA5A5_A5A5, 1'b0);
  endtask

  // req held high: expect ack (and ready) every third sample
  task automatic test_back_to_back();
    logic exp_ack;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      exp_ack = ((i % 3) == 0);
      vectors++;
      if (bus_a.ack !== exp_ack) begin
        miscompares++;
        $display("FAIL b2b_ack[%0d]: got %b expected %b", i, bus_a.ack, exp_ack);
      end
      vectors++;
      if (bus_a.ready !== exp_ack) begin
        miscompares++;
        $display("FAIL b2b_ready[%0d]: got %b expected %b", i, bus_a.ready, exp_ack);
      end
      if (exp_ack) begin
        vectors++;
        if (bus_a.rdata !== 32'hA5A5_A5A5) begin
          miscompares++;
          $display("FAIL b2b_rdata[%0d]: got %h expected a5a5a5a5", i, bus_a.rdata);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_latency1();
    int lat; logic [31:0] rd; logic e;
    xfer(1'b1, 1'b1, 32'h44, 32'h0BAD_CAFE, 1'b0, 1'b0, lat, rd, e);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL lat1_store latency: got %0d expected 1", lat);
    end
    xfer(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, lat, rd, e);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL lat1_load latency: got %0d expected 1", lat);
    end
    vectors++;
    if (rd !== 32'h0BAD_CAFE) begin
      miscompares++;
      $display("FAIL lat1_load rdata: got %h expected 0badcafe", rd);
    end
    xfer(1'b1, 1'b0, 32'h46, 32'h0, 1'b1, 1'b0, lat, rd, e);
    vectors++;
    if (rd !== 32'h0000_0BAD || e !== 1'b0) begin
      miscompares++;
      $display("FAIL lat1_half46: got %h err %b expected 00000bad err 0", rd, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_latency1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
